// File: rtl/ucode_sequencer_if.sv
// Bundle of sequencer control/program/status signals between the datapath side
// (master) and the microcode sequencer (slave).
interface ucode_sequencer_if #(
  parameter int CW  = 15,
  parameter int AW  = 4,
  parameter int FSW = 1
);
  localparam int NF = 2 ** FSW;
  localparam int MW = CW + 3 + FSW + AW;

  // start is a single-cycle request taken only while idle (no ready: it is
  // dropped if the sequencer is busy or finishing); done is a one-cycle pulse
  // the cycle after the HALT word executes. busy is high exactly in RUN.
  logic          start;
  logic [AW-1:0] entry_addr;
  logic [NF-1:0] flags;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [MW-1:0] prog_data;
  logic [CW-1:0] o_signal;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;
  logic [1:0]    fsm_state;

  modport master (
    output start, entry_addr, flags, prog_we, prog_addr, prog_data,
    input  o_signal, busy, done, pc, fsm_state
  );

  modport slave (
    input  start, entry_addr, flags, prog_we, prog_addr, prog_data,
    output o_signal, busy, done, pc, fsm_state
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Microprogrammed control unit: steps a loadable microcode RAM, one control word
// per cycle, with flag branches, a hardware loop counter and start/done.
module ucode_sequencer #(
  parameter int CW   = 15,
  parameter int AW   = 4,
  parameter int FSW  = 1,
  parameter int CNTW = 4
) (
  input  logic             clk,
  input  logic             rst,
  ucode_sequencer_if.slave bus
);
  localparam int MW    = CW + 3 + FSW + AW;
  localparam int DEPTH = 2 ** AW;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRT  = 3'd2;
  localparam logic [2:0] OP_BRF  = 3'd3;
  localparam logic [2:0] OP_LDC  = 3'd4;
  localparam logic [2:0] OP_DJNZ = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_WAIT = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   pc_q, pc_nxt, pc_inc;
  logic [CNTW-1:0] cnt_q, cnt_nxt;
  logic [MW-1:0]   mem [DEPTH];
  logic [MW-1:0]   word;
  logic [CW-1:0]   ctrl;
  logic [2:0]      op;
  logic [FSW-1:0]  fsel;
  logic [AW-1:0]   target;
  logic            flag;

  assign word   = mem[pc_q];
  assign ctrl   = word[MW-1 -: CW];
  assign op     = word[AW+FSW +: 3];
  assign fsel   = word[AW +: FSW];
  assign target = word[AW-1:0];
  assign flag   = bus.flags[fsel];
  assign pc_inc = pc_q + 1'b1;

  // RAM has no reset so a program survives rst; writes are locked out once running.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state == IDLE) mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (op == OP_HALT) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pc_nxt  = pc_q;
    cnt_nxt = cnt_q;
    case (state)
      IDLE: if (bus.start) pc_nxt = bus.entry_addr;
      RUN: begin
        case (op)
          OP_NEXT: pc_nxt = pc_inc;
          OP_JMP:  pc_nxt = target;
          OP_BRT:  pc_nxt = flag ? target : pc_inc;
          OP_BRF:  pc_nxt = flag ? pc_inc : target;
          OP_LDC: begin
            cnt_nxt = CNTW'(target);
            pc_nxt  = pc_inc;
          end
          OP_DJNZ: begin
            if (cnt_q != '0) begin
              cnt_nxt = cnt_q - 1'b1;
              pc_nxt  = target;
            end else begin
              pc_nxt = pc_inc;
            end
          end
          OP_HALT: pc_nxt = pc_q;
          default: if (flag) pc_nxt = pc_inc;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    bus.o_signal  = (state == RUN) ? ctrl : '0;
    bus.busy      = (state == RUN);
    bus.done      = (state == DONE);
    bus.pc        = pc_q;
    bus.fsm_state = state;
  end
endmodule

// File: tb/tb_ucode_sequencer.sv
// Randomized lockstep bench for ucode_sequencer against a field-level program model,
// plus directed straight-line, branch, loop, wait/wrap, lockout and reset runs.
module tb_ucode_sequencer;
  localparam int CW = 15, AW = 4, FSW = 1, CNTW = 4, DEPTH = 16;

  typedef struct { int ctrl; int op; int fsel; int target; } uw_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ucode_sequencer_if #(.CW(CW), .AW(AW), .FSW(FSW)) bus ();
  ucode_sequencer #(.CW(CW), .AW(AW), .FSW(FSW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  uw_t  m_mem [DEPTH];
  int   m_phase, m_pc, m_cnt;   // phase: 0 idle, 1 running, 2 finishing
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] got_q[$];

  function automatic uw_t mk(input int ctrl, input int op, input int fsel, input int target);
    uw_t w;
    w.ctrl = ctrl; w.op = op; w.fsel = fsel; w.target = target;
    return w;
  endfunction

  function automatic uw_t rnd_uw();
    int op;
    op = $urandom_range(0, 9);
    if (op > 7) op = 6;
    return mk($urandom_range(0, 32767), op, $urandom_range(0, 1), $urandom_range(0, 15));
  endfunction

  function automatic logic [22:0] pack_uw(input uw_t w);
    return {w.ctrl[14:0], w.op[2:0], w.fsel[0:0], w.target[3:0]};
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic cycle(input bit st, input int ea, input int fl, input bit we,
                       input int wa, input uw_t wd, output bit ob_busy, output bit ob_done);
    uw_t w;
    int  nxt, flag;
    @(negedge clk);
    check_val("o_signal", int'(bus.o_signal), (m_phase == 1) ? m_mem[m_pc].ctrl : 0);
    check_val("busy", int'(bus.busy), (m_phase == 1) ? 1 : 0);
    check_val("done", int'(bus.done), (m_phase == 2) ? 1 : 0);
    check_val("pc", int'(bus.pc), m_pc);
    ob_busy = bus.busy;
    ob_done = bus.done;
    if (bus.busy) got_q.push_back(bus.o_signal);
    bus.start      = st;
    bus.entry_addr = ea[3:0];
    bus.flags      = fl[1:0];
    bus.prog_we    = we;
    bus.prog_addr  = wa[3:0];
    bus.prog_data  = pack_uw(wd);
    case (m_phase)
      0: begin
        if (we) m_mem[wa] = wd;
        if (st) begin m_phase = 1; m_pc = ea; end
      end
      1: begin
        w    = m_mem[m_pc];
        nxt  = (m_pc + 1) % DEPTH;
        flag = (fl >> w.fsel) & 1;
        case (w.op)
          0: m_pc = nxt;
          1: m_pc = w.target;
          2: m_pc = flag ? w.target : nxt;
          3: m_pc = flag ? nxt : w.target;
          4: begin m_cnt = w.target % 16; m_pc = nxt; end
          5: if (m_cnt != 0) begin m_cnt = m_cnt - 1; m_pc = w.target; end
             else m_pc = nxt;
          6: m_phase = 2;
          default: if (flag) m_pc = nxt;
        endcase
      end
      default: m_phase = 0;
    endcase
    @(posedge clk);
  endtask

  task automatic load(input int addr, input uw_t w);
    bit b, d;
    cycle(1'b0, 0, 0, 1'b1, addr, w, b, d);
  endtask

  // Reset applied between edges; outputs must clear without a clock, and a
  // start held during reset must not launch a run.
  task automatic do_reset_mid();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.prog_we = 1'b0;
    #1;
    check_val("rst_o_signal", int'(bus.o_signal), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_done", int'(bus.done), 0);
    check_val("rst_pc", int'(bus.pc), 0);
    m_phase = 0; m_pc = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    check_val("rst_start_ignored", int'(bus.busy), 0);
    check_val("rst_pc_hold", int'(bus.pc), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
  endtask

  // fl < 0 means random flags each cycle; flags read 0 until cycle hi_after.
  task automatic run(input int entry, input int fl, input int hi_after, input bit noise,
                     input bit wr_at_start, input uw_t ws, input int max_cyc,
                     output int nbusy, output int ndone);
    bit b, d;
    int i, f;
    nbusy = 0; ndone = 0;
    got_q.delete();
    cycle(1'b1, entry, 0, wr_at_start, entry, ws, b, d);
    i = 1;
    while (m_phase != 0 && i < max_cyc) begin
      f = (fl < 0) ? $urandom_range(0, 3) : ((i < hi_after) ? 0 : fl);
      cycle(noise ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 15), f,
            noise, m_pc, rnd_uw(), b, d);
      nbusy += int'(b);
      ndone += int'(d);
      i++;
    end
    if (m_phase != 0) do_reset_mid();
  endtask

  task automatic cmp_trace(input string tag);
    check_val({tag, "_len"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check_val(tag, int'(got_q[k]), int'(exp_q[k]));
  endtask

  initial begin
    int nb, nd;
    rst = 1'b1;
    bus.start = 1'b0; bus.entry_addr = '0; bus.flags = '0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    m_phase = 0; m_pc = 0; m_cnt = 0;
    #3;
    check_val("init_o_signal", int'(bus.o_signal), 0);
    check_val("init_busy", int'(bus.busy), 0);
    check_val("init_done", int'(bus.done), 0);
    check_val("init_pc", int'(bus.pc), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < DEPTH; a++) load(a, mk($urandom_range(0, 32767), 6, 0, 0));

    // straight line
    load(0, mk(15'h6200, 0, 0, 0));
    load(1, mk(15'h0201, 0, 0, 0));
    load(2, mk(15'h4203, 6, 0, 0));
    exp_q = '{15'h6200, 15'h0201, 15'h4203};
    run(0, 0, 0, 1'b0, 1'b0, mk(0, 0, 0, 0), 50, nb, nd);
    check_val("line_busy_cycles", nb, 3);
    check_val("line_done_cycles", nd, 1);
    cmp_trace("line_trace");

    // branches, both polarities of both branch ops
    load(1, mk(15'h0111, 2, 1, 5));
    load(2, mk(15'h0222, 6, 0, 0));
    load(5, mk(15'h0555, 6, 0, 0));
    exp_q = '{15'h6200, 15'h0111, 15'h0555};
    run(0, 2, 0, 1'b0, 1'b0, mk(0, 0, 0, 0), 50, nb, nd);
    cmp_trace("brt_taken");
    exp_q = '{15'h6200, 15'h0111, 15'h0222};
    run(0, 0, 0, 1'b0, 1'b0, mk(0, 0, 0, 0), 50, nb, nd);
    cmp_trace("brt_not_taken");
    load(1, mk(15'h0111, 3, 1, 5));
    exp_q = '{15'h6200, 15'h0111, 15'h0222};
    run(0, 2, 0, 1'b0, 1'b0, mk(0, 0, 0, 0), 50, nb, nd);
    cmp_trace("brf_not_taken");
    exp_q = '{15'h6200, 15'h0111, 15'h0555};
    run(0, 0, 0, 1'b0, 1'b0, mk(0, 0, 0, 0), 50, nb, nd);
    cmp_trace("brf_taken");

    // hardware loop
    load(0, mk(15'h0100, 4, 0, 3));
    load(1, mk(15'h0101, 0, 0, 0));
    load(2, mk(15'h0102, 5, 0, 1));
    load(3, mk(15'h0103, 6, 0, 0));
    run(0, 0, 0, 1'b0, 1'b0, mk(0, 0, 0, 0), 50, nb, nd);
    check_val("loop_busy_cycles", nb, 10);
    check_val("loop_body_count", int'(got_q.size() > 0), 1);
    nd = 0;
    foreach (got_q[k]) if (got_q[k] == 15'h0101) nd++;
    check_val("loop_body_count", nd, 4);

    // wait at the top address then wrap to 0
    load(15, mk(15'h7777, 7, 0, 9));
    load(0, mk(15'h0100, 6, 0, 0));
    exp_q = '{15'h7777, 15'h7777, 15'h7777, 15'h7777, 15'h7777, 15'h7777, 15'h0100};
    run(15, 1, 6, 1'b0, 1'b0, mk(0, 0, 0, 0), 50, nb, nd);
    check_val("wait_busy_cycles", nb, 7);
    cmp_trace("wait_trace");

    // program lockout during RUN, then write-and-start in one cycle
    load(0, mk(15'h6200, 0, 0, 0));
    load(1, mk(15'h0201, 0, 0, 0));
    load(2, mk(15'h4203, 6, 0, 0));
    exp_q = '{15'h6200, 15'h0201, 15'h4203};
    run(0, 0, 0, 1'b1, 1'b0, mk(0, 0, 0, 0), 50, nb, nd);
    cmp_trace("lock_run1");
    run(0, 0, 0, 1'b0, 1'b0, mk(0, 0, 0, 0), 50, nb, nd);
    cmp_trace("lock_run2");
    exp_q = '{15'h1234};
    run(0, 0, 0, 1'b0, 1'b1, mk(15'h1234, 6, 0, 0), 50, nb, nd);
    cmp_trace("write_start");

    // random programs, noisy start/write during RUN, reset if still running
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 4; k++) load($urandom_range(0, 15), rnd_uw());
      run($urandom_range(0, 15), -1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          rnd_uw(), $urandom_range(5, 30), nb, nd);
    end

    do_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
